// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file (R0-R14, R15 = PC).
// Three bypassed read ports; a write to R15 becomes a PC load request.
module wb_register_file (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Load_In,
    input  logic        rf_In,
    input  logic [31:0] Data_Mem_In,
    input  logic [31:0] Alu_In,
    input  logic [3:0]  Rd_In,
    input  logic [3:0]  Ra_Sel,
    input  logic [3:0]  Rb_Sel,
    input  logic [3:0]  Rc_Sel,
    input  logic [31:0] Pc_In,
    output logic [31:0] Ra_Out,
    output logic [31:0] Rb_Out,
    output logic [31:0] Rc_Out,
    output logic [31:0] Wb_Data_Out,
    output logic        Pc_Load_Out,
    output logic [31:0] Pc_Value_Out,
    output logic [15:0] Wb_Count_Out
);

    logic [31:0] regs_q [15];
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [31:0] wb_data;
    logic        rd_is_pc;
    logic        wr_en;
    logic        pc_load;

    assign wb_data  = Load_In ? Data_Mem_In : Alu_In;
    assign rd_is_pc = (Rd_In == 4'hF);
    // CLR gates the bypass and PC request so reads see the cleared array
    assign wr_en    = rf_In && !rd_is_pc && !CLR;
    assign pc_load  = rf_In && rd_is_pc && !CLR;
    assign count_d  = count_q + 16'd1;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (wr_en) begin
            regs_q[Rd_In] <= wb_data;
            count_q       <= count_d;
        end
    end

    function automatic logic [31:0] read_port(
        input logic [3:0]  sel,
        input logic [31:0] arr_val,
        input logic [31:0] pc,
        input logic        byp_en,
        input logic [3:0]  rd,
        input logic [31:0] wdata
    );
        logic [31:0] val;
        val = arr_val;
        if (sel == 4'hF) begin
            val = pc;
        end else if (byp_en && (sel == rd)) begin
            val = wdata;
        end
        return val;
    endfunction

    logic [31:0] ra_arr;
    logic [31:0] rb_arr;
    logic [31:0] rc_arr;

    always_comb begin
        ra_arr = '0;
        rb_arr = '0;
        rc_arr = '0;
        if (Ra_Sel != 4'hF) ra_arr = regs_q[Ra_Sel];
        if (Rb_Sel != 4'hF) rb_arr = regs_q[Rb_Sel];
        if (Rc_Sel != 4'hF) rc_arr = regs_q[Rc_Sel];
    end

    always_comb begin
        Ra_Out = read_port(Ra_Sel, ra_arr, Pc_In, wr_en, Rd_In, wb_data);
        Rb_Out = read_port(Rb_Sel, rb_arr, Pc_In, wr_en, Rd_In, wb_data);
        Rc_Out = read_port(Rc_Sel, rc_arr, Pc_In, wr_en, Rd_In, wb_data);
    end

    assign Wb_Data_Out  = wb_data;
    assign Pc_Load_Out  = pc_load;
    assign Pc_Value_Out = pc_load ? wb_data : 32'h0;
    assign Wb_Count_Out = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file; expected values queued on stimulus,
// popped and asserted against the DUT at each sample point.
module tb_wb_register_file;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        Load_In;
    logic        rf_In;
    logic [31:0] Data_Mem_In;
    logic [31:0] Alu_In;
    logic [3:0]  Rd_In;
    logic [3:0]  Ra_Sel;
    logic [3:0]  Rb_Sel;
    logic [3:0]  Rc_Sel;
    logic [31:0] Pc_In;
    logic [31:0] Ra_Out;
    logic [31:0] Rb_Out;
    logic [31:0] Rc_Out;
    logic [31:0] Wb_Data_Out;
    logic        Pc_Load_Out;
    logic [31:0] Pc_Value_Out;
    logic [15:0] Wb_Count_Out;

    int checks = 0;
    int errors = 0;
    logic [31:0] sbq [$];

    always #5 CLK = ~CLK;

    wb_register_file dut (
        .CLK(CLK),
        .CLR(CLR),
        .Load_In(Load_In),
        .rf_In(rf_In),
        .Data_Mem_In(Data_Mem_In),
        .Alu_In(Alu_In),
        .Rd_In(Rd_In),
        .Ra_Sel(Ra_Sel),
        .Rb_Sel(Rb_Sel),
        .Rc_Sel(Rc_Sel),
        .Pc_In(Pc_In),
        .Ra_Out(Ra_Out),
        .Rb_Out(Rb_Out),
        .Rc_Out(Rc_Out),
        .Wb_Data_Out(Wb_Data_Out),
        .Pc_Load_Out(Pc_Load_Out),
        .Pc_Value_Out(Pc_Value_Out),
        .Wb_Count_Out(Wb_Count_Out)
    );

    task automatic expect_val(input logic [31:0] v);
        sbq.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, observed %h", tag, obs);
            return;
        end
        exp_v = sbq.pop_front();
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CLR = 1'b1;
        Load_In = 1'b0;
        rf_In = 1'b0;
        Data_Mem_In = '0;
        Alu_In = '0;
        Rd_In = '0;
        Ra_Sel = 4'd3;
        Rb_Sel = '0;
        Rc_Sel = '0;
        Pc_In = 32'h40;
        #3;
        expect_val(32'h0); chk("rst_count", {16'h0, Wb_Count_Out});
        expect_val(32'h0); chk("rst_ra", Ra_Out);
        @(negedge CLK);
        CLR = 1'b0;

        // write R3 then clear it asynchronously between edges
        rf_In = 1'b1; Alu_In = 32'h1234; Rd_In = 4'd3;
        tick();
        rf_In = 1'b0;
        #1;
        expect_val(32'h1234); chk("r3_written", Ra_Out);
        expect_val(32'h1); chk("r3_count", {16'h0, Wb_Count_Out});
        #1 CLR = 1'b1;
        #1;
        expect_val(32'h0); chk("async_clr_ra", Ra_Out);
        expect_val(32'h0); chk("async_clr_count", {16'h0, Wb_Count_Out});

        // while CLR: no PC request, no bypass
        rf_In = 1'b1; Rd_In = 4'hF; Alu_In = 32'h100;
        #1;
        expect_val(32'h0); chk("clr_pcload", {31'h0, Pc_Load_Out});
        expect_val(32'h0); chk("clr_pcval", Pc_Value_Out);
        Rd_In = 4'd3;
        #1;
        expect_val(32'h0); chk("clr_nobypass", Ra_Out);
        tick();
        expect_val(32'h0); chk("clr_nowrite", Ra_Out);

        // pending write discarded by CLR asserted before the edge
        @(negedge CLK);
        CLR = 1'b0;
        rf_In = 1'b1; Rd_In = 4'd4; Alu_In = 32'h55;
        #1 CLR = 1'b1;
        tick();
        @(negedge CLK);
        CLR = 1'b0; rf_In = 1'b0; Ra_Sel = 4'd4;
        #1;
        expect_val(32'h0); chk("discard_r4", Ra_Out);
        expect_val(32'h0); chk("discard_count", {16'h0, Wb_Count_Out});

        // ALU write
        rf_In = 1'b1; Load_In = 1'b0; Alu_In = 32'hDEADBEEF; Rd_In = 4'd5;
        tick();
        rf_In = 1'b0; Rb_Sel = 4'd5;
        #1;
        expect_val(32'hDEADBEEF); chk("alu_rb", Rb_Out);
        expect_val(32'h1); chk("alu_count", {16'h0, Wb_Count_Out});

        // load select with same-cycle bypass on all ports
        rf_In = 1'b1; Load_In = 1'b1; Data_Mem_In = 32'hA5A5A5A5;
        Alu_In = 32'h0; Rd_In = 4'd2;
        Ra_Sel = 4'd2; Rb_Sel = 4'd2; Rc_Sel = 4'd2;
        #1;
        expect_val(32'hA5A5A5A5); chk("byp_wbdata", Wb_Data_Out);
        expect_val(32'hA5A5A5A5); chk("byp_ra", Ra_Out);
        expect_val(32'hA5A5A5A5); chk("byp_rb", Rb_Out);
        expect_val(32'hA5A5A5A5); chk("byp_rc", Rc_Out);
        expect_val(32'h1); chk("byp_count_pre", {16'h0, Wb_Count_Out});
        tick();
        rf_In = 1'b0; Load_In = 1'b0;
        #1;
        expect_val(32'hA5A5A5A5); chk("arr_ra", Ra_Out);
        expect_val(32'hA5A5A5A5); chk("arr_rb", Rb_Out);
        expect_val(32'hA5A5A5A5); chk("arr_rc", Rc_Out);
        expect_val(32'h2); chk("load_count", {16'h0, Wb_Count_Out});

        // R15 write becomes a PC load request
        rf_In = 1'b1; Rd_In = 4'hF; Alu_In = 32'h100;
        Pc_In = 32'h40; Ra_Sel = 4'hF;
        #1;
        expect_val(32'h1); chk("pc_load", {31'h0, Pc_Load_Out});
        expect_val(32'h100); chk("pc_value", Pc_Value_Out);
        expect_val(32'h40); chk("r15_read", Ra_Out);
        tick();
        rf_In = 1'b0;
        #1;
        expect_val(32'h2); chk("pc_count", {16'h0, Wb_Count_Out});
        expect_val(32'h0); chk("pc_load_off", {31'h0, Pc_Load_Out});
        expect_val(32'h0); chk("pc_value_off", Pc_Value_Out);

        // disabled write leaves R7 and count alone
        rf_In = 1'b1; Rd_In = 4'd7; Alu_In = 32'h77;
        tick();
        rf_In = 1'b0; Alu_In = 32'hFFFF; Rc_Sel = 4'd7;
        #1;
        expect_val(32'h77); chk("dis_nobypass", Rc_Out);
        tick();
        expect_val(32'h77); chk("dis_r7", Rc_Out);
        expect_val(32'h3); chk("dis_count", {16'h0, Wb_Count_Out});

        // back-to-back writes, last wins
        rf_In = 1'b1; Rd_In = 4'd6; Alu_In = 32'h1;
        tick();
        Alu_In = 32'h2;
        tick();
        rf_In = 1'b0; Rb_Sel = 4'd6;
        #1;
        expect_val(32'h2); chk("b2b_r6", Rb_Out);
        expect_val(32'h5); chk("b2b_count", {16'h0, Wb_Count_Out});

        // counter wrap after 65536 writes from reset
        @(negedge CLK);
        CLR = 1'b1;
        #1 CLR = 1'b0;
        rf_In = 1'b1; Rd_In = 4'd1; Ra_Sel = 4'd1;
        for (int i = 0; i < 65536; i++) begin
            Alu_In = 32'(i);
            if (i == 65535) begin
                #1;
                expect_val(32'h0000FFFF);
                chk("wrap_pre", {16'h0, Wb_Count_Out});
            end
            tick();
        end
        rf_In = 1'b0; Alu_In = 32'h0;
        #1;
        expect_val(32'h0); chk("wrap_count", {16'h0, Wb_Count_Out});
        expect_val(32'h0000FFFF); chk("wrap_r1", Ra_Out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and architectural register file for the 5-stage ARM pipeline. Consumes the MEM/WB pipeline register outputs, selects write-back data (memory vs ALU), commits it to one of 15 general registers (R0–R14), and serves three read ports to the ID stage. Same-cycle write-to-read bypass makes WB results visible to ID without an extra forwarding path. Writes to R15 are redirected to the PC as a branch request.

## Interface
- No parameters; data width fixed at 32, register index 4 bits.

- CLK  in  1  pipeline clock; all state updates on rising edge
- CLR  in  1  reset, asynchronous, active-high
- Load_In  in  1  from MEM/WB: 1 = write memory data, 0 = write ALU result
- rf_In  in  1  from MEM/WB: register-file write enable
- Data_Mem_In  in  32  from MEM/WB: load data
- Alu_In  in  32  from MEM/WB: ALU result
- Rd_In  in  4  from MEM/WB: destination register
- Ra_Sel, Rb_Sel, Rc_Sel  in  4 each  ID-stage read selects (Rn, Rm, Rd-for-store)
- Pc_In  in  32  current PC+8 value, returned on reads of R15
- Ra_Out, Rb_Out, Rc_Out  out  32 each  read data
- Wb_Data_Out  out  32  selected write-back value (for forwarding to EX)
- Pc_Load_Out  out  1  write to R15 in progress this cycle
- Pc_Value_Out  out  32  value to load into PC when Pc_Load_Out = 1
- Wb_Count_Out  out  16  number of committed register writes since reset

## Operation
- Wb_Data_Out = Load_In ? Data_Mem_In : Alu_In (combinational, always driven).
- Write condition: rf_In = 1 and Rd_In != 4'hF → on rising CLK, R[Rd_In] <= Wb_Data_Out; Wb_Count_Out increments by 1.
- Wb_Count_Out wraps 16'hFFFF → 16'h0000; no saturation.
- rf_In = 1 and Rd_In = 4'hF: no register array write, no count increment; Pc_Load_Out = 1 and Pc_Value_Out = Wb_Data_Out combinationally the same cycle. Otherwise Pc_Load_Out = 0, Pc_Value_Out = 0.
- Read port x (Ra/Rb/Rc), combinational, priority order:
  - Sel = 4'hF → Pc_In.
  - rf_In = 1 and Sel = Rd_In (≠ F) → Wb_Data_Out (bypass).
  - else → R[Sel].
- All three ports independent; any combination of equal selects legal.
- rf_In = 0: Load_In, Data_Mem_In, Alu_In, Rd_In do not affect state.

## Timing
- Reset (CLR = 1, asynchronous): R0–R14 = 0, Wb_Count_Out = 0 immediately, without waiting for CLK. While CLR held, all writes suppressed and count held at 0; read ports still combinational (return 0 for R0–R14, Pc_In for R15, bypass disabled → return 0).
- Pc_Load_Out / Pc_Value_Out forced 0 while CLR = 1.
- CLR asserted mid-cycle with a pending write: write discarded. CLR deasserted: first write commits on the first rising CLK with CLR = 0.
- Write latency: value visible on read ports combinationally in the write cycle (bypass), from the array from the next cycle on.
- Pc_Load_Out: zero-latency, combinational, one cycle per qualifying WB instruction; no internal PC register.
- Back-to-back writes to the same register every cycle legal; last write wins.

## Test plan
- Reset: pulse CLR between clock edges after writing R3 = 32'h1234 → Ra_Sel=3 reads 0 immediately, Wb_Count_Out = 0.
- ALU write: rf_In=1, Load_In=0, Alu_In=32'hDEADBEEF, Rd_In=5, one edge, then rf_In=0 → Rb_Out (Rb_Sel=5) = 32'hDEADBEEF, Wb_Count_Out = 1.
- Load select + bypass: rf_In=1, Load_In=1, Data_Mem_In=32'hA5A5A5A5, Alu_In=32'h0, Rd_In=2, Ra/Rb/Rc_Sel=2 before edge → all three ports = 32'hA5A5A5A5 in same cycle and after edge.
- R15 write: rf_In=1, Rd_In=15, Alu_In=32'h100 → Pc_Load_Out=1, Pc_Value_Out=32'h100, Wb_Count_Out unchanged; Ra_Sel=15 with Pc_In=32'h40 → 32'h40.
- Disabled write: rf_In=0, Rd_In=7, Alu_In=32'hFFFF → R7 stays previous value, no bypass, count unchanged.
- Counter wrap: 65536 consecutive writes to R1 → Wb_Count_Out returns to 0; R1 holds last value.
